// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the datapath.
// Fetches an instruction through PC/MAR/MDR and decodes IRVal. It then steps the
// datapath through T3..T6 for binary ALU, mul/div, unary, nop and halt instructions.
// Ports:
//   Clock, reset (async active-low)  - clock and reset
//   IRVal [BITS]                      - instruction register contents from the datapath
//   Stop                              - pause request, honoured only at instruction boundaries
//   PCin..IncPC, HIout, LOout         - per-cycle datapath strobes (HIout/LOout held at 0)
//   ADD..NOT                          - ALU operation selects, at most one high
//   GPRin, GPRout [REGISTERS]         - one-hot register write / drive selects
//   Run, InstrDone, InstrCount[16]    - run status, final-step flag, retired-instruction count
module control_sequencer #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REGISTERS = 16
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [BITS-1:0]      IRVal,
    input  logic                 Stop,
    output logic                 PCin,
    output logic                 PCout,
    output logic                 IRin,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 Read,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 IncPC,
    output logic                 HIout,
    output logic                 LOout,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 Run,
    output logic                 InstrDone,
    output logic [15:0]          InstrCount
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [1:0] {CL_NOP, CL_BIN, CL_MD, CL_UN} iclass_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_instr_count;
    logic [4:0]           w_opcode;
    iclass_t              w_class;
    logic                 w_last_step;
    logic [REGISTERS-1:0] w_ra_hot;
    logic [REGISTERS-1:0] w_rb_hot;
    logic [REGISTERS-1:0] w_rc_hot;
    logic                 w_unused_ir;

    assign w_opcode    = IRVal[31:27];
    assign w_ra_hot    = REGISTERS'(1) << IRVal[26:23];
    assign w_rb_hot    = REGISTERS'(1) << IRVal[22:19];
    assign w_rc_hot    = REGISTERS'(1) << IRVal[18:15];
    assign w_unused_ir = ^IRVal[14:0];

    // Instruction class selects the length and shape of the execute phase.
    always_comb begin
        w_class = CL_NOP;
        unique case (w_opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: w_class = CL_BIN;
            5'b01110, 5'b01111:                     w_class = CL_MD;
            5'b10000, 5'b10001:                     w_class = CL_UN;
            default:                                w_class = CL_NOP;
        endcase
    end

    // Final step of the current instruction depends on its class.
    always_comb begin
        w_last_step = 1'b0;
        unique case (r_state)
            S_T3:    w_last_step = (w_class == CL_NOP);
            S_T4:    w_last_step = (w_class == CL_UN);
            S_T5:    w_last_step = (w_class == CL_BIN);
            S_T6:    w_last_step = 1'b1;
            default: w_last_step = 1'b0;
        endcase
    end

    // Next-state logic; Stop only matters in IDLE and at a final step.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: w_next_state = Stop ? S_IDLE : S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_T2;
            S_T2:   w_next_state = S_T3;
            S_T3, S_T4, S_T5, S_T6: begin
                if (w_last_step) begin
                    if (w_opcode == 5'b11011) w_next_state = S_HALT;
                    else if (Stop)            w_next_state = S_IDLE;
                    else                      w_next_state = S_T0;
                end else begin
                    w_next_state = state_t'(4'(r_state) + 4'd1);
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and retired-instruction counter.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_last_step) r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign InstrCount = r_instr_count;
    assign InstrDone  = w_last_step;
    assign Run        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign HIout      = 1'b0;
    assign LOout      = 1'b0;

    // Moore strobe decode; the state register reset clears every strobe immediately.
    always_comb begin
        PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; Read = 1'b0; RYin = 1'b0; RZin = 1'b0; Zlowout = 1'b0;
        Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0;
        ADD = 1'b0; SUB = 1'b0; SHR = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0;
        AND = 1'b0; OR = 1'b0; MUL = 1'b0; DIV = 1'b0; NEGATE = 1'b0; NOT = 1'b0;
        GPRin = '0; GPRout = '0;
        unique case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (w_class == CL_BIN || w_class == CL_MD) begin
                    GPRout = w_rb_hot;
                    RYin   = 1'b1;
                end else if (w_class == CL_UN) begin
                    GPRout = w_rb_hot;
                    RZin   = 1'b1;
                    NEGATE = (w_opcode == 5'b10000);
                    NOT    = (w_opcode == 5'b10001);
                end
            end
            S_T4: begin
                if (w_class == CL_BIN || w_class == CL_MD) begin
                    GPRout = w_rc_hot;
                    RZin   = 1'b1;
                    ADD    = (w_opcode == 5'b00011);
                    SUB    = (w_opcode == 5'b00100);
                    SHR    = (w_opcode == 5'b00101);
                    SHL    = (w_opcode == 5'b00110);
                    ROR    = (w_opcode == 5'b00111);
                    ROL    = (w_opcode == 5'b01000);
                    AND    = (w_opcode == 5'b01001);
                    OR     = (w_opcode == 5'b01010);
                    MUL    = (w_opcode == 5'b01110);
                    DIV    = (w_opcode == 5'b01111);
                end else if (w_class == CL_UN) begin
                    Zlowout = 1'b1;
                    GPRin   = w_ra_hot;
                end
            end
            S_T5: begin
                if (w_class == CL_BIN) begin
                    Zlowout = 1'b1;
                    GPRin   = w_ra_hot;
                end else if (w_class == CL_MD) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus side pushes the expected
// per-cycle strobe snapshots of each instruction; a monitor pops and compares.
module tb_control_sequencer;

    logic        Clock;
    logic        reset;
    logic [31:0] IRVal;
    logic        Stop;
    logic PCin, PCout, IRin, MARin, MDRin, MDRout, Read, RYin, RZin, Zlowout, Zhighout;
    logic HIin, LOin, IncPC, HIout, LOout;
    logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT;
    logic [15:0] GPRin, GPRout;
    logic Run, InstrDone;
    logic [15:0] InstrCount;

    control_sequencer #(.BITS(32), .REGISTERS(16)) dut (
        .Clock(Clock), .reset(reset), .IRVal(IRVal), .Stop(Stop),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .RYin(RYin), .RZin(RZin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .HIout(HIout), .LOout(LOout),
        .ADD(ADD), .SUB(SUB), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .AND(AND), .OR(OR), .MUL(MUL), .DIV(DIV), .NEGATE(NEGATE), .NOT(NOT),
        .GPRin(GPRin), .GPRout(GPRout), .Run(Run), .InstrDone(InstrDone),
        .InstrCount(InstrCount)
    );

    typedef struct packed {
        logic pcin, pcout, irin, marin, mdrin, mdrout, read, ryin, rzin, zlo, zhi;
        logic hiin, loin, hiout, loout, incpc;
        logic [11:0] alu;     // [11]=ADD ... [0]=NOT
        logic [15:0] gprin;
        logic [15:0] gprout;
        logic run;
        logic done;
        logic [15:0] cnt;
    } snap_t;

    snap_t act;
    assign act = {PCin, PCout, IRin, MARin, MDRin, MDRout, Read, RYin, RZin, Zlowout,
                  Zhighout, HIin, LOin, HIout, LOout, IncPC,
                  ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT,
                  GPRin, GPRout, Run, InstrDone, InstrCount};

    snap_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_count = '0;
    logic [15:0] idle_cnt = '0;
    bit          mon_en = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_snap(input string name, input snap_t a, input snap_t e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, a, e);
        end
    endtask

    // Reference model: expected snapshot sequence for one instruction, from the opcode tables.
    function automatic void push_expect(input logic [31:0] ins, input logic [15:0] cnt);
        snap_t b, s;
        int op, kind, alu_idx;   // kind: 0 nop-like, 1 binary, 2 mul/div, 3 unary
        logic [15:0] ra, rb, rc;
        op = int'(ins[31:27]);
        ra = 16'(1) << ins[26:23];
        rb = 16'(1) << ins[22:19];
        rc = 16'(1) << ins[18:15];
        kind = 0; alu_idx = 0;
        if (op >= 3 && op <= 10) begin kind = 1; alu_idx = 11 - (op - 3); end
        else if (op == 14 || op == 15) begin kind = 2; alu_idx = 3 - (op - 14); end
        else if (op == 16 || op == 17) begin kind = 3; alu_idx = 1 - (op - 16); end
        b = '0; b.run = 1'b1; b.cnt = cnt;
        s = b; s.pcout = 1; s.marin = 1; s.incpc = 1; s.rzin = 1; exp_q.push_back(s);
        s = b; s.zlo = 1; s.pcin = 1; s.read = 1; s.mdrin = 1;    exp_q.push_back(s);
        s = b; s.mdrout = 1; s.irin = 1;                           exp_q.push_back(s);
        if (kind == 0) begin
            s = b; s.done = 1; exp_q.push_back(s);
        end else if (kind == 3) begin
            s = b; s.gprout = rb; s.alu[alu_idx] = 1'b1; s.rzin = 1; exp_q.push_back(s);
            s = b; s.zlo = 1; s.gprin = ra; s.done = 1;               exp_q.push_back(s);
        end else begin
            s = b; s.gprout = rb; s.ryin = 1;                         exp_q.push_back(s);
            s = b; s.gprout = rc; s.alu[alu_idx] = 1'b1; s.rzin = 1; exp_q.push_back(s);
            if (kind == 1) begin
                s = b; s.zlo = 1; s.gprin = ra; s.done = 1; exp_q.push_back(s);
            end else begin
                s = b; s.zlo = 1; s.loin = 1;           exp_q.push_back(s);
                s = b; s.zhi = 1; s.hiin = 1; s.done = 1; exp_q.push_back(s);
            end
        end
    endfunction

    // Monitor: running cycles pop the scoreboard, idle cycles must be silent.
    always @(negedge Clock) begin
        snap_t e;
        if (mon_en) begin
            if (Run) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_run actual=%h expected=no active step", act);
                end else begin
                    e = exp_q.pop_front();
                    check_snap("step", act, e);
                    if (e.done) idle_cnt = e.cnt + 16'd1;
                end
            end else begin
                e = '0; e.cnt = idle_cnt;
                check_snap("idle", act, e);
            end
        end
    end

    // Issue one instruction; IRVal is presented right after the IRin cycle, as the datapath would.
    task automatic run_instr(input logic [31:0] ins, input logic stop_after);
        bit seen;
        push_expect(ins, model_count);
        model_count = model_count + 16'd1;
        Stop = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (IRin) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL fetch_timeout actual=IRin low expected=IRin within 20 cycles");
            return;
        end
        @(posedge Clock); #1;
        IRVal = ins;
        Stop  = stop_after;
        if (stop_after) begin
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge Clock);
                if (InstrDone) seen = 1;
            end
            if (!seen) begin
                n_checks++; n_errors++;
                $display("FAIL done_timeout actual=InstrDone low expected=InstrDone within 10 cycles");
            end
            repeat (2) @(negedge Clock);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  op;
        bit          seen;
        reset = 1'b0; Stop = 1'b1; IRVal = '0;

        repeat (2) @(negedge Clock) check_snap("reset_low", act, '0);
        reset = 1'b1;
        repeat (3) @(negedge Clock) check_snap("idle_stop", act, '0);
        idle_cnt = '0;
        mon_en = 1;

        run_instr(32'h4A920000, 1'b0);   // and R5,R2,R4
        run_instr(32'h701B0000, 1'b0);   // mul R3,R6
        run_instr(32'h88B80000, 1'b1);   // not R1,R7, then pause

        // Reset during T4 of an AND: strobes must clear before the next edge.
        run_instr(32'h4A920000, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clock);
            if (GPRout == 16'h0010 && RZin) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL t4_timeout actual=no T4 seen expected=T4 within 10 cycles");
        end
        #2;
        mon_en = 0;
        reset = 1'b0; Stop = 1'b1;
        #1;
        check_snap("reset_async", act, '0);
        exp_q.delete();
        model_count = '0;
        idle_cnt = '0;
        @(negedge Clock) check_snap("reset_hold", act, '0);
        reset = 1'b1;
        @(negedge Clock) check_snap("reset_release", act, '0);
        mon_en = 1;

        // Random instruction stream; halt is reserved for the end.
        for (int n = 0; n < 200; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            ins = {op, 27'($urandom)};
            run_instr(ins, ($urandom_range(0, 7) == 0));
        end

        run_instr(32'hF8000000, 1'b0);   // illegal opcode acts as nop
        run_instr(32'hD8000000, 1'b0);   // halt
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            n_checks++;
            if (Run !== 1'b0 || InstrCount !== model_count) begin
                n_errors++;
                $display("FAIL halt_sticky actual=Run %b count %0d expected=Run 0 count %0d",
                         Run, InstrCount, model_count);
            end
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_steps actual=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `datapath` and generates every per-cycle control strobe the datapath needs. It fetches an instruction through the PC/MAR/MDR path and decodes `IRVal`. It then steps the datapath through the T0–T6 micro-sequence for register-to-register ALU, multiply/divide, NOP and HALT instructions. It also reports run status and a retired-instruction count.

## Interface
Parameters:
- BITS, 32, data/instruction width
- REGISTERS, 16, GPR count; must be 16, because register fields are 4 bits

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low
- IRVal  in  BITS  instruction register contents from `datapath`
- Stop  in  1  pause request, sampled only at instruction boundaries
- PCin, PCout, IRin, MARin, MDRin, MDRout, Read, RYin, RZin, Zlowout, Zhighout, HIin, LOin, IncPC  out  1 each  datapath strobes
- HIout, LOout  out  1 each  always 0; reserved for future use
- ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT  out  1 each  ALU operation selects; at most one high at a time
- GPRin, GPRout  out  REGISTERS  one-hot register write/drive selects
- Run  out  1  high in states T0–T6
- InstrDone  out  1  high during the final step of each instruction
- InstrCount  out  16  retired-instruction counter

## Operation
- Instruction fields:
  - opcode = IRVal[31:27]
  - Ra = IRVal[26:23]
  - Rb = IRVal[22:19]
  - Rc = IRVal[18:15]
- Opcodes:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010 (binary)
  - mul 01110, div 01111
  - neg 10000, not 10001 (unary)
  - nop 11010, halt 11011
  - Every other opcode executes as nop.
- Outputs are Moore-style: decoded combinationally from the state register and, in T3–T6, from the IRVal fields. No strobe not listed for a state is asserted in it.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Fetch strobes:
  - T0: PCout, MARin, IncPC, RZin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- Binary ops:
  - T3: GPRout[Rb], RYin
  - T4: GPRout[Rc], op select, RZin
  - T5 (final): Zlowout, GPRin[Ra]
- mul/div (Ra is ignored):
  - T3: GPRout[Rb], RYin
  - T4: GPRout[Rc], MUL or DIV, RZin
  - T5: Zlowout, LOin
  - T6 (final): Zhighout, HIin
- Unary ops:
  - T3: GPRout[Rb], NEGATE or NOT, RZin
  - T4 (final): Zlowout, GPRin[Ra]
- nop, illegal and halt: T3 is the final step, with no strobes except InstrDone.
- Transitions:
  - IDLE → T0 when Stop=0; otherwise stay in IDLE.
  - T0 → T1 → T2 → T3 unconditionally.
  - From the final step: → HALT if the opcode is halt; else → IDLE if Stop=1; else → T0.
  - HALT is sticky until reset.
- InstrCount increments on the edge leaving any final step, including halt, nop and illegal. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset (reset=0): asynchronously forces state=IDLE and InstrCount=0. All outputs are 0 while reset is low and in the cycle after release.
- Reset asserted mid-instruction: every strobe drops immediately, without waiting for a clock edge. No partial GPRin pulse is completed.
- Latency from the first T0 edge to the final step:
  - 5 cycles for binary ops
  - 6 cycles for mul/div
  - 4 cycles for unary ops
  - 3 cycles for nop/halt
- Back-to-back instructions: the cycle after a final step is T0, with no gap when Stop=0.
- Stop is ignored in T0 through the non-final steps. Raising Stop mid-instruction lets the instruction complete, then the FSM enters IDLE.
- IRVal is sampled only in T3–T6. It is stable there because IRin is asserted only in T2.
- GPRin and GPRout are exactly one-hot when used, and 0 in every other state.

## Test plan
- Reset with Stop=1: all outputs 0, Run=0, InstrCount=0. The FSM stays in IDLE for 3 cycles.
- Stop=0 with IRVal=0x4A920000 (and R5,R2,R4):
  - T0–T2 show the fetch strobes.
  - T3: GPRout=0x0004, RYin=1.
  - T4: GPRout=0x0010, AND=1, RZin=1.
  - T5: GPRin=0x0020, Zlowout=1, InstrDone=1.
  - InstrCount=1; the next state is T0.
- IRVal=0x701B0000 (mul R3,R6):
  - T3: GPRout=0x0008.
  - T4: GPRout=0x0040, MUL=1.
  - T5: LOin=1, Zlowout=1.
  - T6: HIin=1, Zhighout=1.
  - GPRin stays 0 throughout.
- IRVal=0x88B80000 (not R1,R7):
  - T3: GPRout=0x0080, NOT=1, RZin=1.
  - T4: GPRin=0x0002, Zlowout=1.
  - Then Stop=1 raised in T3 → the instruction completes, the FSM enters IDLE and Run=0.
- Reset pulled low during T4 of the AND instruction: outputs are 0 before the next edge, and InstrCount=0.
- IRVal=0xF8000000 (illegal): InstrDone is asserted in T3 with no other strobes, and the count increments. Then IRVal=0xD8000000 (halt): the FSM reaches HALT and Run stays 0 for 10 cycles despite Stop=0.
